fifo_write_arbiter: RTL

Round-robin arbiter that shares the single write port of the asynchronous FIFO between several requesters in the write clock domain. It grants one requester at a time for a bounded burst, drives the FIFO `w_en`/`data_in` directly, and honours the FIFO `full` flag so no write is ever attempted while full. The block sits between the producer blocks and the FIFO write interface.

---
 rtl/fifo_write_arbiter_pkg.sv | 19 +
 rtl/fifo_write_arbiter_rr_picker.sv | 30 +++
 rtl/fifo_write_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter and its
// round-robin picker.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // A single requester still needs a one-bit id field.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin search: first set req bit strictly after 'last',
// wrapping modulo NUM_REQ (which need not be a power of two).
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               found,
    output logic [ID_W-1:0]    next_id
);

    logic [ID_W-1:0] idx_s;
    logic            hit_s;

    // Scan last+1 .. last+NUM_REQ; 'last' itself is checked last.
    always_comb begin
        found   = 1'b0;
        next_id = last;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_s   = ID_W'((int'(last) + i) % NUM_REQ);
            hit_s   = ~found & req[idx_s];
            next_id = hit_s ? idx_s : next_id;
            found   = found | hit_s;
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between NUM_REQ
// requesters, granting bounded bursts and never writing while full.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  MAX_BURST  = 4,
    localparam int ID_W       = id_width(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam int                CNT_W     = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]   LAST_INIT = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ACK_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t                state_r;
    logic [ID_W-1:0]       grant_id_r;
    logic [ID_W-1:0]       last_r;
    logic [CNT_W-1:0]      burst_cnt_r;

    logic                  found_s;
    logic [ID_W-1:0]       next_id_s;
    logic                  busy_s;
    logic                  req_g_s;
    logic                  w_en_s;
    logic [DATA_WIDTH-1:0] sel_data_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req     (req),
        .last    (last_r),
        .found   (found_s),
        .next_id (next_id_s)
    );

    // Granted requester's valid/data mux and the full-gated write strobe.
    always_comb begin
        busy_s     = (state_r == ST_BURST);
        req_g_s    = 1'b0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_g_s    = (grant_id_r == ID_W'(i)) ? req[i] : req_g_s;
            sel_data_s = (grant_id_r == ID_W'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : sel_data_s;
        end
        w_en_s = busy_s & req_g_s & ~full;
    end

    // Write strobe is combinational so a rising 'full' blocks the write in the same cycle.
    assign w_en     = w_en_s;
    assign ack      = w_en_s ? (ACK_ONE << grant_id_r) : '0;
    assign data_in  = w_en_s ? sel_data_s : '0;
    assign grant_id = grant_id_r;
    assign busy     = busy_s;

    // Arbitration FSM: one arbitration cycle in IDLE, then a burst of up to MAX_BURST words.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_r     <= ST_IDLE;
            grant_id_r  <= '0;
            last_r      <= LAST_INIT;
            burst_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_id_r  <= next_id_s;
                        burst_cnt_r <= '0;
                        state_r     <= ST_BURST;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (!req_g_s) begin
                        state_r <= ST_IDLE;
                        last_r  <= grant_id_r;
                    end else if (w_en_s) begin
                        burst_cnt_r <= burst_cnt_r + CNT_W'(1);
                        if (burst_cnt_r == LAST_BEAT) begin
                            state_r <= ST_IDLE;
                            last_r  <= grant_id_r;
                        end else begin
                            state_r <= ST_BURST;
                        end
                    end else begin
                        // Stalled on full: hold grant and count.
                        state_r <= ST_BURST;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
